// File: rtl/serv_mdu_pkg.sv
// Shared constants, state encoding and operand-signedness helpers for the RV32M unit.
package serv_mdu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/serv_mdu_sign.sv
// Operand pre-conditioning (magnitudes, sign flags) and result post-correction.
module serv_mdu_sign
  import serv_mdu_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] abs1_c,
  output logic [XLEN-1:0] abs2_c,
  output logic            rs1_neg_c,
  output logic            rs2_neg_c,
  input  logic [2:0]      op_q,
  input  logic            rs1_neg_q,
  input  logic            rs2_neg_q,
  input  logic            dbz_q,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] res_c
);

  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   lo_neg;
  logic [XLEN-1:0]   hi_neg;
  logic              neg_res;

  assign rs1_neg_c = rs1_signed(op) & rs1[XLEN-1];
  assign rs2_neg_c = rs2_signed(op) & rs2[XLEN-1];
  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude
  assign abs1_c = rs1_neg_c ? -rs1 : rs1;
  assign abs2_c = rs2_neg_c ? -rs2 : rs2;

  assign prod_neg = -{hi, lo};
  assign lo_neg   = -lo;
  assign hi_neg   = -hi;
  assign neg_res  = rs1_neg_q ^ rs2_neg_q;

  // hi holds product-high / remainder, lo holds product-low / quotient
  always_comb begin
    res_c = lo;
    case (op_q)
      OP_MUL:            res_c = lo;
      OP_MULH, OP_MULHSU: res_c = neg_res ? prod_neg[2*XLEN-1:XLEN] : hi;
      OP_MULHU:          res_c = hi;
      OP_DIV:            res_c = dbz_q ? '1 : (neg_res ? lo_neg : lo);
      OP_DIVU:           res_c = dbz_q ? '1 : lo;
      // a zero divisor leaves the dividend in the remainder, so REM needs no bypass
      OP_REM:            res_c = rs1_neg_q ? hi_neg : hi;
      default:           res_c = hi;
    endcase
  end

endmodule

// File: rtl/serv_mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per clock.
module serv_mdu
  import serv_mdu_pkg::*;
#(
  parameter RESET_STRATEGY = "MINI"
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mdu_valid,
  input  logic [2:0]      i_mdu_op,
  input  logic [XLEN-1:0] i_mdu_rs1,
  input  logic [XLEN-1:0] i_mdu_rs2,
  output logic [XLEN-1:0] o_mdu_rd,
  output logic            o_mdu_ready
);

  localparam int unsigned AW     = XLEN + 1;
  localparam bit          RST_DP = (RESET_STRATEGY != "NONE");

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              load, step, fix, done;

  logic [2:0]        op_q;
  logic              rs1_neg_q, rs2_neg_q, dbz_q;
  logic [XLEN-1:0]   acc, opa, opb;
  logic [XLEN-1:0]   acc_n, opa_n;

  logic [XLEN-1:0]   abs1_c, abs2_c, res_c;
  logic              rs1_neg_c, rs2_neg_c;

  logic              div;
  logic [AW-1:0]     sh, add_a, add_b, sum;
  logic              nonneg;

  serv_mdu_sign u_sign (
    .op        (i_mdu_op),
    .rs1       (i_mdu_rs1),
    .rs2       (i_mdu_rs2),
    .abs1_c    (abs1_c),
    .abs2_c    (abs2_c),
    .rs1_neg_c (rs1_neg_c),
    .rs2_neg_c (rs2_neg_c),
    .op_q      (op_q),
    .rs1_neg_q (rs1_neg_q),
    .rs2_neg_q (rs2_neg_q),
    .dbz_q     (dbz_q),
    .hi        (acc),
    .lo        (opa),
    .res_c     (res_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_mdu_ready <= 1'b0;
      o_mdu_rd    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= step ? cnt + CNT_W'(1) : '0;
      o_mdu_ready <= done;
      if (fix) o_mdu_rd <= res_c;
    end
  end

  // Ready-cycle valid still belongs to the finished request, so it is not re-accepted
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (i_mdu_valid && !o_mdu_ready) begin
        state_n = RUN;
        load    = 1'b1;
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(XLEN - 1)) state_n = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Single 33-bit adder shared by multiply accumulate and divide trial subtract
  always_comb begin
    div    = is_div(op_q);
    sh     = {acc, opa[XLEN-1]};
    add_a  = div ? sh : {1'b0, acc};
    add_b  = div ? ~{1'b0, opb} : (opa[0] ? {1'b0, opb} : '0);
    sum    = add_a + add_b + AW'(div);
    nonneg = ~sum[XLEN];
    acc_n  = sum[XLEN:1];
    opa_n  = {sum[0], opa[XLEN-1:1]};
    if (div) begin
      acc_n = nonneg ? sum[XLEN-1:0] : sh[XLEN-1:0];
      opa_n = {opa[XLEN-2:0], nonneg};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && RST_DP) begin
      op_q      <= '0;
      rs1_neg_q <= 1'b0;
      rs2_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      acc       <= '0;
      opa       <= '0;
      opb       <= '0;
    end else if (load) begin
      op_q      <= i_mdu_op;
      rs1_neg_q <= rs1_neg_c;
      rs2_neg_q <= rs2_neg_c;
      dbz_q     <= (i_mdu_rs2 == '0);
      acc       <= '0;
      opa       <= abs1_c;
      opb       <= abs2_c;
    end else if (step) begin
      acc       <= acc_n;
      opa       <= opa_n;
    end
  end

endmodule

// File: tb/tb_serv_mdu.sv
// Self-checking bench for serv_mdu: directed RV32M cases plus randomized ops vs. an arithmetic model.
module tb_serv_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [31:0] rd;
  logic        ready;

  int checks = 0;
  int errors = 0;

  serv_mdu #(.RESET_STRATEGY("MINI")) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mdu_valid (valid),
    .i_mdu_op    (op),
    .i_mdu_rs1   (rs1),
    .i_mdu_rs2   (rs2),
    .o_mdu_rd    (rd),
    .o_mdu_ready (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  // RV32M semantics straight from the ISA rules, using 64-bit integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  // Issue one request and wait for its ready pulse; optionally disturb inputs mid-run
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit perturb, input string tag);
    int n;
    bit seen;
    logic [31:0] res;
    op = f; rs1 = a; rs2 = b; valid = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 0;
    res = '0;
    while (!seen && n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) begin
        seen = 1;
        res = rd;
      end
      if (perturb && n == 10) begin
        op = ~f; rs1 = ~a; rs2 = b ^ 32'h5A5A_0001;
      end
      if (perturb && n == 20) valid = 1'b0;
    end
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd34);
    check({tag, "_rd"}, res, ref_mdu(f, a, b));
    @(posedge clk);
    #1;
    check({tag, "_pulse_width"}, 32'(ready), 32'd0);
    check({tag, "_rd_hold"}, rd, ref_mdu(f, a, b));
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rd", rd, 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'd6, 0, "mul_7x6");
    check("mul_7x6_const", rd, 32'h0000_002A);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_m1");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
    check("mulhu_max_const", rd, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
    check("mulhsu_m1_const", rd, 32'hFFFF_FFFF);
    run_op(3'd4, -32'd7, 32'd2, 0, "div_m7_2");
    check("div_m7_2_const", rd, 32'hFFFF_FFFD);
    run_op(3'd6, -32'd7, 32'd2, 0, "rem_m7_2");
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 0, "divu");
    check("divu_const", rd, 32'h7FFF_FFFC);
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 0, "remu");
    run_op(3'd4, 32'd5, 32'd0, 0, "div_by0");
    run_op(3'd6, 32'd5, 32'd0, 0, "rem_by0");
    check("rem_by0_const", rd, 32'd5);
    run_op(3'd6, -32'd9, 32'd0, 0, "rem_neg_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    check("div_ovf_const", rd, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
    run_op(3'd4, 32'd1000, -32'd7, 1, "perturb_div");
    run_op(3'd1, 32'h1234_5678, -32'd3, 1, "perturb_mulh");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 0, "rand");
    end

    // Reset in the middle of a divide must cancel it silently
    run_op(3'd4, 32'd100, 32'd7, 0, "pre_rst");
    op = 3'd4; rs1 = 32'd12345; rs2 = 32'd11; valid = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_rd", rd, 32'd0);
    rst = 1'b0;
    run_op(3'd0, 32'd3, 32'd3, 0, "post_rst_mul");
    check("post_rst_mul_const", rd, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule
